// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - N-way AXI4 read-channel arbiter, one burst outstanding, grant locked AR to RLAST
module axi_read_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ*8-1:0]          s_arlen,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy,
    output logic                          protocol_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                  state;
    logic [IDW-1:0]          rr_ptr;
    logic [7:0]              beat_cnt;
    logic [IDW-1:0]          win;
    logic                    found;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [7:0]              win_len;
    logic [IDW-1:0]          next_ptr;
    logic                    beat;

    // Search starts at rr_ptr (round-robin) or at 0 (fixed priority) and wraps.
    always_comb begin
        int             idx_full;
        logic [IDW-1:0] idx;
        win      = '0;
        found    = 1'b0;
        idx_full = 0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_full = (FIXED_PRIO != 0) ? k : (int'(rr_ptr) + k) % NUM_REQ;
            idx      = idx_full[IDW-1:0];
            if (!found && s_arvalid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDW'(i)) begin
                win_addr = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_len  = s_arlen[i*8 +: 8];
            end
        end
    end

    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                s_arready[i] = (state == ADDR) && m_arready;
                s_rvalid[i]  = (state == DATA) && m_rvalid;
            end
        end
    end

    assign m_arvalid = (state == ADDR);
    assign m_rready  = (state == DATA) && s_rready[grant_id];
    assign busy      = (state != IDLE);
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign beat      = m_rvalid && m_rready;
    assign next_ptr  = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            beat_cnt     <= '0;
            protocol_err <= 1'b0;
            m_araddr     <= '0;
            m_arlen      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= win;
                        m_araddr <= win_addr;
                        m_arlen  <= win_len;
                        beat_cnt <= '0;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready)
                        state <= DATA;
                end
                DATA: begin
                    if (beat) begin
                        if (beat_cnt != 8'hFF)
                            beat_cnt <= beat_cnt + 8'd1;
                        // RLAST must coincide exactly with the beat numbered m_arlen.
                        if (m_rlast != (beat_cnt == m_arlen))
                            protocol_err <= 1'b1;
                        if (m_rlast) begin
                            state <= IDLE;
                            if (FIXED_PRIO == 0)
                                rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - scoreboard bench for axi_read_arbiter, round-robin and fixed-priority instances
module tb_axi_read_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    s_arvalid, s_rready;
    logic [N*AW-1:0] s_araddr;
    logic [N*8-1:0]  s_arlen;
    logic            m_arready, m_rvalid, m_rlast;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;

    logic [N-1:0]    rr_s_arready, rr_s_rvalid, fp_s_arready, fp_s_rvalid;
    logic [DW-1:0]   rr_s_rdata, fp_s_rdata;
    logic [1:0]      rr_s_rresp, fp_s_rresp;
    logic            rr_s_rlast, fp_s_rlast;
    logic            rr_m_arvalid, fp_m_arvalid, rr_m_rready, fp_m_rready;
    logic [AW-1:0]   rr_m_araddr, fp_m_araddr;
    logic [7:0]      rr_m_arlen, fp_m_arlen;
    logic [0:0]      rr_grant_id, fp_grant_id;
    logic            rr_busy, fp_busy, rr_perr, fp_perr;

    axi_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(rr_s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(rr_s_rvalid), .s_rready(s_rready), .s_rdata(rr_s_rdata), .s_rresp(rr_s_rresp),
        .s_rlast(rr_s_rlast),
        .m_arvalid(rr_m_arvalid), .m_arready(m_arready), .m_araddr(rr_m_araddr), .m_arlen(rr_m_arlen),
        .m_rvalid(m_rvalid), .m_rready(rr_m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast),
        .grant_id(rr_grant_id), .busy(rr_busy), .protocol_err(rr_perr)
    );

    axi_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(fp_s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(fp_s_rvalid), .s_rready(s_rready), .s_rdata(fp_s_rdata), .s_rresp(fp_s_rresp),
        .s_rlast(fp_s_rlast),
        .m_arvalid(fp_m_arvalid), .m_arready(m_arready), .m_araddr(fp_m_araddr), .m_arlen(fp_m_arlen),
        .m_rvalid(m_rvalid), .m_rready(fp_m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast),
        .grant_id(fp_grant_id), .busy(fp_busy), .protocol_err(fp_perr)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic [0:0]  gid;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;

    ar_t        rr_ar_q[$], fp_ar_q[$];
    r_t         r_q[$];
    ar_t        e_rr, e_fp;
    r_t         e_r;
    logic [0:0] cur_gid;

    always @(negedge clk) begin
        if (!rst) begin
            if (rr_m_arvalid && m_arready) begin
                if (rr_ar_q.size() == 0) check("rr_ar_unexpected", 1, 0);
                else begin
                    e_rr = rr_ar_q.pop_front();
                    check("rr_grant_id", rr_grant_id, e_rr.gid);
                    check("rr_m_araddr", rr_m_araddr, e_rr.addr);
                    check("rr_m_arlen",  rr_m_arlen,  e_rr.len);
                    check("rr_s_arready", rr_s_arready, 2'b01 << e_rr.gid);
                end
            end
            if (fp_m_arvalid && m_arready) begin
                if (fp_ar_q.size() == 0) check("fp_ar_unexpected", 1, 0);
                else begin
                    e_fp = fp_ar_q.pop_front();
                    check("fp_grant_id", fp_grant_id, e_fp.gid);
                    check("fp_m_araddr", fp_m_araddr, e_fp.addr);
                    check("fp_m_arlen",  fp_m_arlen,  e_fp.len);
                end
            end
            if (m_rvalid && rr_m_rready) begin
                if (r_q.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    e_r = r_q.pop_front();
                    check("rr_s_rvalid", rr_s_rvalid, e_r.mask);
                    check("rr_s_rdata",  rr_s_rdata,  e_r.data);
                    check("rr_s_rresp",  rr_s_rresp,  e_r.resp);
                    check("rr_s_rlast",  rr_s_rlast,  e_r.last);
                end
            end
        end
    end

    function automatic logic [31:0] addr_of(input logic [0:0] g);
        return g ? s_araddr[63:32] : s_araddr[31:0];
    endfunction

    function automatic logic [7:0] len_of(input logic [0:0] g);
        return g ? s_arlen[15:8] : s_arlen[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_ar(input logic [1:0] req, input logic [1:0] after,
                            input logic [0:0] g_rr, input logic [0:0] g_fp);
        ar_t a;
        a.gid = g_rr; a.addr = addr_of(g_rr); a.len = len_of(g_rr);
        rr_ar_q.push_back(a);
        a.gid = g_fp; a.addr = addr_of(g_fp); a.len = len_of(g_fp);
        fp_ar_q.push_back(a);
        cur_gid   = g_rr;
        s_arvalid = req;
        step();
        step();
        s_arvalid = after;
    endtask

    task automatic send_beats(input int n, input int last_at, input logic [31:0] base);
        r_t r;
        for (int b = 0; b < n; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(b);
            m_rresp  = 2'(b);
            m_rlast  = (b == last_at);
            r.mask = 2'b01 << cur_gid; r.data = m_rdata; r.resp = m_rresp; r.last = m_rlast;
            r_q.push_back(r);
            step();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        s_arvalid = 2'b11;
        s_rready  = 2'b11;
        m_arready = 1'b1;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        cur_gid   = '0;
        s_araddr  = {32'h0000_2000, 32'h0000_1000};
        s_arlen   = 16'h0000;

        repeat (2) begin
            @(negedge clk);
            check("rst_m_arvalid", {rr_m_arvalid, fp_m_arvalid}, 2'b00);
            check("rst_s_arready", {rr_s_arready, fp_s_arready}, 4'b0000);
            check("rst_busy",      {rr_busy, fp_busy}, 2'b00);
            check("rst_perr",      {rr_perr, fp_perr}, 2'b00);
            check("rst_m_araddr",  rr_m_araddr, 32'h0);
            check("rst_grant_id",  rr_grant_id, 1'b0);
        end
        step();
        rst = 1'b0;

        // Both requesting: round-robin alternates, fixed priority keeps requester 0.
        issue_ar(2'b11, 2'b11, 1'b0, 1'b0); send_beats(1, 0, 32'hB0);
        issue_ar(2'b11, 2'b11, 1'b1, 1'b0); send_beats(1, 0, 32'hB1);
        issue_ar(2'b11, 2'b11, 1'b0, 1'b0); send_beats(1, 0, 32'hB2);
        issue_ar(2'b11, 2'b11, 1'b1, 1'b0); send_beats(1, 0, 32'hB3);
        issue_ar(2'b11, 2'b10, 1'b0, 1'b0); send_beats(1, 0, 32'hB4);
        issue_ar(2'b10, 2'b00, 1'b1, 1'b1); send_beats(1, 0, 32'hB5);
        check("idle_busy", {rr_busy, fp_busy}, 2'b00);

        s_araddr[63:32] = 32'h0000_0100;
        s_arlen[15:8]   = 8'd3;
        issue_ar(2'b10, 2'b00, 1'b1, 1'b1);
        send_beats(4, 3, 32'hA0);
        check("single_busy", {rr_busy, fp_busy}, 2'b00);
        check("single_perr", {rr_perr, fp_perr}, 2'b00);

        s_araddr[31:0] = 32'h0000_0300;
        s_arlen[7:0]   = 8'd3;
        issue_ar(2'b01, 2'b00, 1'b0, 1'b0);
        send_beats(2, 1, 32'hC0);
        check("early_perr", {rr_perr, fp_perr}, 2'b11);
        check("early_busy", {rr_busy, fp_busy}, 2'b00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("perr_cleared", {rr_perr, fp_perr}, 2'b00);

        s_arlen[7:0] = 8'd1;
        issue_ar(2'b01, 2'b00, 1'b0, 1'b0);
        send_beats(3, 2, 32'hD0);
        check("late_perr", {rr_perr, fp_perr}, 2'b11);
        check("late_busy", {rr_busy, fp_busy}, 2'b00);
        check("late_all_beats", r_q.size(), 0);

        s_arlen[7:0] = 8'd7;
        issue_ar(2'b01, 2'b00, 1'b0, 1'b0);
        send_beats(1, -1, 32'hE0);
        rst      = 1'b1;
        m_rvalid = 1'b1;
        step();
        check("mid_busy",     {rr_busy, fp_busy}, 2'b00);
        check("mid_m_rready", {rr_m_rready, fp_m_rready}, 2'b00);
        check("mid_s_rvalid", {rr_s_rvalid, fp_s_rvalid}, 4'b0000);
        check("mid_perr",     {rr_perr, fp_perr}, 2'b00);
        rst      = 1'b0;
        m_rvalid = 1'b0;

        // rr_ptr was 1 before the abort; reset must bring it back to 0.
        s_arlen[7:0] = 8'd0;
        issue_ar(2'b11, 2'b00, 1'b0, 1'b0);
        send_beats(1, 0, 32'hF0);
        check("post_rst_perr", {rr_perr, fp_perr}, 2'b00);

        step();
        check("rr_ar_q_drained", rr_ar_q.size(), 0);
        check("fp_ar_q_drained", fp_ar_q.size(), 0);
        check("r_q_drained",     r_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
Parametrised N-requester AXI4 read-channel arbiter that generalises the two-way instruction/data cache arbiter in front of the core's single external m_axi port. It grants one requester at a time (round-robin or fixed priority) and locks the grant for a whole burst, from AR handshake to RLAST. It latches the winning address and length, and counts beats to detect RLAST protocol violations. The write channels are outside its scope: the data cache write path connects to the external AW/W/B channels directly.

Parameters:
NUM_REQ, 2, number of read requesters (>=2); requester 0 = instruction cache, 1 = data cache.
ADDR_WIDTH, 32, AR address width.
DATA_WIDTH, 32, R data width.
FIXED_PRIO, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
IDW, $clog2(NUM_REQ), width of grant index (local, not overridable).

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
s_arvalid  in  NUM_REQ  per-requester AR valid
s_arready  out  NUM_REQ  per-requester AR ready
s_araddr  in  NUM_REQ*ADDR_WIDTH  packed per-requester AR address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
s_arlen  in  NUM_REQ*8  packed per-requester AXI burst length (beats-1)
s_rvalid  out  NUM_REQ  per-requester R valid
s_rready  in  NUM_REQ  per-requester R ready
s_rdata  out  DATA_WIDTH  shared R data (broadcast; qualified by s_rvalid[i])
s_rresp  out  2  shared R response
s_rlast  out  1  shared R last
m_arvalid  out  1  external AR valid
m_arready  in  1  external AR ready
m_araddr  out  ADDR_WIDTH  external AR address (registered)
m_arlen  out  8  external AR length (registered)
m_rvalid  in  1  external R valid
m_rready  out  1  external R ready
m_rdata  in  DATA_WIDTH  external R data
m_rresp  in  2  external R response
m_rlast  in  1  external R last
grant_id  out  IDW  index of current owner; valid while busy
busy  out  1  high in ADDR and DATA
protocol_err  out  1  sticky; set on RLAST/beat-count mismatch, cleared only by rst

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. rr_ptr=0, grant_id=0, beat_cnt=0, protocol_err=0, m_araddr=0, m_arlen=0. All valid/ready outputs 0.
- FSM IDLE -> ADDR -> DATA -> IDLE. Only one burst is outstanding at a time.
- IDLE: s_arready=0 and m_arvalid=0. If any s_arvalid is high, the winner W is computed combinationally.
  - Round-robin: first asserted index searching upward from rr_ptr, with wrap at NUM_REQ-1 -> 0.
  - Fixed priority: lowest asserted index.
  - At the next posedge: grant_id<=W, m_araddr<=s_araddr[W], m_arlen<=s_arlen[W], beat_cnt<=0, state<=ADDR.
  - Arbitration latency is 1 cycle from s_arvalid to m_arvalid.
- ADDR: m_arvalid=1 and s_arready[grant_id]=m_arready; other s_arready bits are 0. On m_arvalid&m_arready: state<=DATA. Requesters hold s_arvalid and payload until their s_arready (AXI rule). The registered payload isolates the external port from any violation.
- DATA:
  - m_rready=s_rready[grant_id]; s_rvalid[grant_id]=m_rvalid; other s_rvalid bits are 0.
  - s_rdata/s_rresp/s_rlast follow m_rdata/m_rresp/m_rlast combinationally.
  - Each beat (m_rvalid&m_rready): beat_cnt<=beat_cnt+1 (8-bit, saturates at 255).
  - Beat with m_rlast=1: state<=IDLE; in round-robin mode rr_ptr<=(grant_id+1) mod NUM_REQ. rr_ptr is unused in fixed mode.
  - Error check: protocol_err<=1 if m_rlast=1 with beat_cnt!=m_arlen (early), or m_rlast=0 with beat_cnt==m_arlen (late). On a late RLAST, stay in DATA until RLAST arrives; never drop a beat.
- A requester withdrawing s_arvalid has no effect on a grant already registered.
- A new request arriving during ADDR/DATA waits; it is evaluated in the first IDLE cycle after RLAST. Minimum back-to-back gap is 1 idle cycle.
- s_rready low stalls via m_rready; beats are never buffered.
- Reset mid-burst aborts immediately to IDLE with all outputs at reset values. The external slave is reset by the same rst.
- m_rresp is forwarded unmodified; SLVERR/DECERR are not interpreted.

Test Plan:
- Reset: hold rst 2 cycles with s_arvalid=2'b11 -> m_arvalid=0, s_arready=0, busy=0, protocol_err=0 throughout. First grant follows 1 cycle after release.
- Single burst: s_arvalid[1]=1, s_araddr[1]=0x0000_0100, s_arlen[1]=3; slave ready immediately.
  - m_arvalid rises 1 cycle later with m_araddr=0x100, m_arlen=3, grant_id=1.
  - 4 beats 0xA0..0xA3 appear on s_rdata with only s_rvalid[1] high.
  - busy falls after beat 4; protocol_err stays 0.
- Round-robin fairness: NUM_REQ=2, both s_arvalid held high, 4 back-to-back bursts of len 0 -> grant order 0,1,0,1.
- Fixed priority: FIXED_PRIO=1, both held high, 3 bursts -> grant order 0,0,0. Requester 1 is served only after s_arvalid[0] drops.
- Protocol errors:
  - arlen=3 with RLAST on beat 2 -> protocol_err=1, FSM back to IDLE.
  - Separate run, arlen=1 with RLAST only on beat 3 -> protocol_err=1 and all 3 beats forwarded.
- Reset mid-DATA: assert rst after beat 1 of a len-7 burst -> next cycle busy=0, m_rready=0, s_rvalid=0, rr_ptr=0. A new request is granted normally afterwards.
